// File: rtl/regfile_sequencer.sv
// regfile_sequencer: multi-cycle controller running one register-to-register
// operation at a time against an external 8x16 register file.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    operation handshake (ready only in IDLE)
//   op, rd, rn, rm, imm, shift   operation fields, captured on accept
//   rf_readnum           register file read index (RDA: rn, RDB: rm)
//   rf_writenum, rf_write, rf_data_in   register file write port (WB only)
//   rf_data_out          register file read data (combinational from readnum)
//   done, illegal        completion pulse, illegal-op pulse (with done)
//   busy                 high whenever not IDLE
//   flag_z/n/v           status flags
//
// Optional feature: define REGFILE_SEQ_SHIFT_EN to apply the shift field to
// the B operand in EXE. Without it the shift field is ignored.
module regfile_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned IMM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        shift,
  output logic [REG_AW-1:0] rf_readnum,
  output logic [REG_AW-1:0] rf_writenum,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic              done,
  output logic              illegal,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RDA  = 3'd1;
  localparam logic [2:0] S_RDB  = 3'd2;
  localparam logic [2:0] S_EXE  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_CMP  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;

  localparam int unsigned MSB = DATA_W - 1;

  logic [2:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic              z_q, z_d, n_q, n_d, v_q, v_d;

  logic [DATA_W-1:0] b_sh;
  logic [DATA_W-1:0] sum, diff, alu_res;
  logic              alu_v, alu_upd;
  logic [DATA_W-1:0] imm_sext;

`ifdef REGFILE_SEQ_SHIFT_EN
  logic [1:0] shift_q, shift_d;

  // B-operand shifter: none / LSL1 / LSR1 / ASR1
  always_comb begin
    unique case (shift_q)
      2'b01:   b_sh = {b_q[MSB-1:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_q[MSB:1]};
      2'b11:   b_sh = {b_q[MSB], b_q[MSB:1]};
      default: b_sh = b_q;
    endcase
  end
`else
  logic shift_unused;
  assign shift_unused = ^shift;
  assign b_sh = b_q;
`endif

  assign sum      = a_q + b_sh;
  assign diff     = a_q - b_sh;
  assign imm_sext = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

  // ALU result and whether the op updates flags
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_upd = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_res = sum;
        alu_v   = (a_q[MSB] == b_sh[MSB]) && (sum[MSB] != a_q[MSB]);
        alu_upd = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff;
        alu_v   = (a_q[MSB] != b_sh[MSB]) && (diff[MSB] != a_q[MSB]);
        alu_upd = 1'b1;
      end
      OP_AND: begin
        alu_res = a_q & b_sh;
        alu_upd = 1'b1;
      end
      OP_NOT: begin
        alu_res = ~b_sh;
        alu_upd = 1'b1;
      end
      OP_MOV:  alu_res = b_sh;
      default: alu_res = '0;
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    imm_d   = imm_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
`ifdef REGFILE_SEQ_SHIFT_EN
    shift_d = shift_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = op;
          rd_d  = rd;
          rn_d  = rn;
          rm_d  = rm;
          imm_d = imm;
`ifdef REGFILE_SEQ_SHIFT_EN
          shift_d = shift;
`endif
          unique case (op)
            OP_MOVI:        state_d = S_WB;
            OP_MOV, OP_NOT: state_d = S_RDB;
            3'b111:         state_d = S_ERR;
            default:        state_d = S_RDA;
          endcase
        end
      end
      S_RDA: begin
        a_d     = rf_data_out;
        state_d = S_RDB;
      end
      S_RDB: begin
        b_d     = rf_data_out;
        state_d = S_EXE;
      end
      S_EXE: begin
        c_d = alu_res;
        if (alu_upd) begin
          z_d = (alu_res == '0);
          n_d = alu_res[MSB];
          v_d = alu_v;
        end
        // CMP finishes here without a writeback
        state_d = (op_q == OP_CMP) ? S_IDLE : S_WB;
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
`ifdef REGFILE_SEQ_SHIFT_EN
      shift_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
`ifdef REGFILE_SEQ_SHIFT_EN
      shift_q <= shift_d;
`endif
    end
  end

  // Moore output decode from state and latched fields only; reset forces
  // state to IDLE asynchronously, which drops rf_write at once.
  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign rf_write    = (state_q == S_WB);
  assign rf_writenum = (state_q == S_WB) ? rd_q : '0;
  assign rf_data_in  = (state_q != S_WB)  ? '0 :
                       (op_q == OP_MOVI)  ? imm_sext : c_q;
  assign rf_readnum  = (state_q == S_RDA) ? rn_q :
                       (state_q == S_RDB) ? rm_q : '0;
  assign done        = (state_q == S_WB) || (state_q == S_ERR) ||
                       ((state_q == S_EXE) && (op_q == OP_CMP));
  assign illegal     = (state_q == S_ERR);
  assign flag_z      = z_q;
  assign flag_n      = n_q;
  assign flag_v      = v_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [2:0]  rd, rn, rm;
  logic [7:0]  imm;
  logic [1:0]  shift;
  logic [2:0]  rf_readnum, rf_writenum;
  logic        rf_write;
  logic [15:0] rf_data_in, rf_data_out;
  logic        done, illegal, busy, flag_z, flag_n, flag_v;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    int          lat;
    logic        wr;
    logic [2:0]  wnum;
    logic [15:0] wdata;
    logic        ill;
    logic        z, n, v;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mreg [8];
  logic        mz = 1'b0, mn = 1'b0, mv = 1'b0;

  // bench-side register file with a poke port for preloading
  logic [15:0] rf [8];
  logic        poke_en = 1'b0;
  logic [2:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;

  always @(posedge clk) begin
    if (poke_en) rf[poke_addr] <= poke_data;
    else if (rf_write) rf[rf_writenum] <= rf_data_in;
  end
  assign rf_data_out = rf[rf_readnum];

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .shift(shift),
    .rf_readnum(rf_readnum), .rf_writenum(rf_writenum), .rf_write(rf_write),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out), .done(done),
    .illegal(illegal), .busy(busy), .flag_z(flag_z), .flag_n(flag_n),
    .flag_v(flag_v)
  );

  function automatic logic [15:0] bshift(input logic [15:0] b, input logic [1:0] sh);
`ifdef REGFILE_SEQ_SHIFT_EN
    case (sh)
      2'b01:   return b << 1;
      2'b10:   return b >> 1;
      2'b11:   return {b[15], b[15:1]};
      default: return b;
    endcase
`else
    if (sh == 2'b00) return b;
    return b;
`endif
  endfunction

  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
    mreg[a] = d;
  endtask

  // Issue one op, push its expectation, wait for done and compare.
  task automatic run_op(input logic [2:0] t_op, input logic [2:0] t_rd,
                        input logic [2:0] t_rn, input logic [2:0] t_rm,
                        input logic [7:0] t_imm, input logic [1:0] t_sh);
    exp_t        e, g;
    logic [15:0] a, b, r;
    int          w, cyc;
    bit          seen;
    a = mreg[t_rn];
    b = bshift(mreg[t_rm], t_sh);
    r = '0;
    e.op = t_op; e.wr = 1'b0; e.wnum = t_rd; e.wdata = '0; e.ill = 1'b0;
    e.z = mz; e.n = mn; e.v = mv; e.lat = 1;
    case (t_op)
      3'b000: begin e.lat = 1; e.wr = 1'b1; e.wdata = {{8{t_imm[7]}}, t_imm}; end
      3'b001: begin e.lat = 3; e.wr = 1'b1; e.wdata = b; end
      3'b010: begin e.lat = 4; e.wr = 1'b1; r = a + b;
                    e.v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'b011: begin e.lat = 3; r = a - b;
                    e.v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'b100: begin e.lat = 4; e.wr = 1'b1; r = a & b; e.v = 1'b0; end
      3'b101: begin e.lat = 3; e.wr = 1'b1; r = ~b; e.v = 1'b0; end
      3'b110: begin e.lat = 4; e.wr = 1'b1; r = a - b;
                    e.v = (a[15] != b[15]) && (r[15] != a[15]); end
      default: begin e.lat = 1; e.ill = 1'b1; end
    endcase
    if (t_op inside {3'b010, 3'b011, 3'b100, 3'b101, 3'b110}) begin
      e.z = (r == 16'h0); e.n = r[15];
      if (t_op != 3'b011) e.wdata = r;
    end
    if (e.wr) mreg[t_rd] = e.wdata;
    mz = e.z; mn = e.n; mv = e.v;
    sbq.push_back(e);

    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL ready_wait: in_ready=%b required 1", in_ready); end

    in_valid = 1'b1; op = t_op; rd = t_rd; rn = t_rn; rm = t_rm; imm = t_imm; shift = t_sh;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); rd = 3'($urandom); rn = 3'($urandom);
    rm = 3'($urandom); imm = 8'($urandom); shift = 2'($urandom);

    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 12) begin
      @(negedge clk); cyc++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        checks++;
        if (rf_write !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL midop op=%0d cyc=%0d: write/ready/busy=%b%b%b required 001",
                   t_op, cyc, rf_write, in_ready, busy);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL done_timeout op=%0d: no done in %0d cycles", t_op, cyc);
      void'(sbq.pop_front());
    end else begin
      g = sbq.pop_front();
      checks++;
      if (cyc != g.lat) begin failures++; $display("FAIL latency op=%0d: got %0d required %0d", g.op, cyc, g.lat); end
      checks++;
      if ({illegal, rf_write} !== {g.ill, g.wr}) begin
        failures++; $display("FAIL ctl op=%0d: illegal/write=%b%b required %b%b", g.op, illegal, rf_write, g.ill, g.wr);
      end
      if (g.wr) begin
        checks++;
        if (rf_writenum !== g.wnum || rf_data_in !== g.wdata) begin
          failures++; $display("FAIL wb op=%0d: num=%0d data=%h required num=%0d data=%h",
                               g.op, rf_writenum, rf_data_in, g.wnum, g.wdata);
        end
      end
      @(negedge clk);
      checks++;
      if ({flag_z, flag_n, flag_v} !== {g.z, g.n, g.v}) begin
        failures++; $display("FAIL flags op=%0d: znv=%b%b%b required %b%b%b", g.op,
                             flag_z, flag_n, flag_v, g.z, g.n, g.v);
      end
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rf_write !== 1'b0) begin
        failures++; $display("FAIL idle_after op=%0d: ready/busy/done/write=%b%b%b%b required 1000",
                             g.op, in_ready, busy, done, rf_write);
      end
      if (g.wr) begin
        checks++;
        if (rf[g.wnum] !== g.wdata) begin
          failures++; $display("FAIL rf_content R%0d: got %h required %h", g.wnum, rf[g.wnum], g.wdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, busy, done, illegal, rf_write, flag_z, flag_n, flag_v} !== 8'b1000_0000 ||
        rf_readnum !== 3'd0 || rf_writenum !== 3'd0 || rf_data_in !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: rdy/busy/done/ill/wr/znv=%b%b%b%b%b%b%b%b rn=%0d wn=%0d din=%h required 10000000 0 0 0000",
               in_ready, busy, done, illegal, rf_write, flag_z, flag_n, flag_v,
               rf_readnum, rf_writenum, rf_data_in);
    end
  endtask

  task automatic test_movi();
    run_op(3'b000, 3'd3, 3'd0, 3'd0, 8'hFB, 2'b00);
    checks++;
    if (rf[3] !== 16'hFFFB || {flag_z, flag_n, flag_v} !== 3'b000) begin
      failures++; $display("FAIL movi_const: R3=%h znv=%b%b%b required fffb 000", rf[3], flag_z, flag_n, flag_v);
    end
  endtask

  task automatic test_add();
    poke(3'd1, 16'h7FFF);
    poke(3'd2, 16'h0001);
    run_op(3'b010, 3'd0, 3'd1, 3'd2, 8'h00, 2'b00);
    checks++;
    if (rf[0] !== 16'h8000 || {flag_z, flag_n, flag_v} !== 3'b011) begin
      failures++; $display("FAIL add_const: R0=%h znv=%b%b%b required 8000 011", rf[0], flag_z, flag_n, flag_v);
    end
  endtask

  task automatic test_cmp();
    poke(3'd4, 16'd5);
    poke(3'd5, 16'd5);
    run_op(3'b011, 3'd6, 3'd4, 3'd5, 8'h00, 2'b00);
    checks++;
    if ({flag_z, flag_n, flag_v} !== 3'b100) begin
      failures++; $display("FAIL cmp_const: znv=%b%b%b required 100", flag_z, flag_n, flag_v);
    end
  endtask

  task automatic test_illegal();
    run_op(3'b111, 3'd2, 3'd1, 3'd1, 8'h00, 2'b00);
  endtask

  task automatic test_shift();
    logic [15:0] req;
`ifdef REGFILE_SEQ_SHIFT_EN
    req = 16'hC001;
`else
    req = 16'h8002;
`endif
    poke(3'd6, 16'h8002);
    run_op(3'b001, 3'd7, 3'd0, 3'd6, 8'h00, 2'b11);
    checks++;
    if (rf[7] !== req) begin failures++; $display("FAIL shift_const: R7=%h required %h", rf[7], req); end
  endtask

  // consecutive ops with minimum gap, including in-place updates
  task automatic test_back_to_back();
    run_op(3'b000, 3'd1, 3'd0, 3'd0, 8'h05, 2'b00);
    run_op(3'b010, 3'd1, 3'd1, 3'd1, 8'h00, 2'b00);
    run_op(3'b110, 3'd2, 3'd3, 3'd1, 8'h00, 2'b00);
    run_op(3'b100, 3'd4, 3'd2, 3'd3, 8'h00, 2'b01);
    run_op(3'b101, 3'd5, 3'd0, 3'd4, 8'h00, 2'b10);
    run_op(3'b111, 3'd0, 3'd0, 3'd0, 8'h00, 2'b00);
    run_op(3'b011, 3'd0, 3'd1, 3'd1, 8'h00, 2'b00);
    run_op(3'b001, 3'd6, 3'd0, 3'd5, 8'h00, 2'b11);
    run_op(3'b110, 3'd0, 3'd0, 3'd2, 8'h00, 2'b00);
    run_op(3'b000, 3'd7, 3'd0, 3'd0, 8'h80, 2'b00);
    run_op(3'b100, 3'd3, 3'd7, 3'd7, 8'h00, 2'b00);
  endtask

  task automatic test_reset_mid_wb();
    int w;
    poke(3'd1, 16'h7FFF);
    poke(3'd2, 16'h0001);
    poke(3'd0, 16'h1234);
    @(negedge clk);
    in_valid = 1'b1; op = 3'b010; rd = 3'd0; rn = 3'd1; rm = 3'd2; imm = 8'h00; shift = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (rf_write !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    checks++;
    if (rf_write !== 1'b1) begin failures++; $display("FAIL wb_reach: rf_write=%b required 1", rf_write); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (rf_write !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL async_abort: write/busy=%b%b required 00", rf_write, busy);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mz = 1'b0; mn = 1'b0; mv = 1'b0;
    @(negedge clk);
    checks++;
    if (rf[0] !== 16'h1234) begin failures++; $display("FAIL abort_rf: R0=%h required 1234", rf[0]); end
    checks++;
    if ({in_ready, busy, flag_z, flag_n, flag_v} !== 5'b10000) begin
      failures++; $display("FAIL abort_state: ready/busy/znv=%b%b%b%b%b required 10000",
                           in_ready, busy, flag_z, flag_n, flag_v);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = '0; rd = '0; rn = '0; rm = '0; imm = '0; shift = '0;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) poke(3'(i), 16'h0);
    test_movi();
    test_add();
    test_cmp();
    test_illegal();
    test_shift();
    test_back_to_back();
    test_reset_mid_wb();
    run_op(3'b010, 3'd3, 3'd1, 3'd2, 8'h00, 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Multi-cycle controller that executes one register-to-register operation at a time against the 8x16 register file.
- Accepts an operation over a valid/ready handshake.
- Drives the register file's readnum/writenum/write/data_in, and captures operands from its data_out.
- Holds operand latches A/B/C, a small ALU and status flags; sits between the instruction source and the register file.

Parameters:
- DATA_W, 16, register/ALU data width.
- REG_AW, 3, register index width (2**REG_AW registers).
- IMM_W, 8, immediate width; sign-extended to DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  high only in IDLE.
- op  input  3  000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 NOT, 110 SUB, 111 reserved.
- rd / rn / rm  input  REG_AW each  destination, first source, second source.
- imm  input  IMM_W  immediate for MOVI.
- shift  input  2  B-operand shift (see Optional Feature).
- rf_readnum  output  REG_AW  register file read index.
- rf_writenum  output  REG_AW  register file write index.
- rf_write  output  1  register file write enable.
- rf_data_in  output  DATA_W  register file write data.
- rf_data_out  input  DATA_W  register file read data (combinational from rf_readnum).
- done  output  1  one-cycle completion pulse.
- illegal  output  1  one-cycle pulse with done for op 111.
- busy  output  1  high whenever state is not IDLE.
- flag_z, flag_n, flag_v  output  1 each  status flags.

Behaviour:
- Reset values: state IDLE; A, B, C = 0; flags 0; all outputs 0 except in_ready = 1.
- Reset asserted mid-operation aborts immediately. rf_write drops asynchronously with the state, so no partial write occurs.
- All outputs are Moore-decoded from state and registered fields. None is combinational from the in_* ports.
- Accept: IDLE and in_valid captures op/rd/rn/rm/imm/shift at the clock edge. Inputs are ignored in every other state.
- States: IDLE, RDA, RDB, EXE, WB, ERR.
- IDLE transitions:
  - MOVI goes to WB.
  - MOV and NOT go to RDB.
  - ADD, SUB, AND, CMP go to RDA.
  - 111 goes to ERR.
- RDA: rf_readnum = rn; A <= rf_data_out; next RDB.
- RDB: rf_readnum = rm; B <= rf_data_out; next EXE.
- rf_readnum = 0 in all states other than RDA and RDB.
- EXE: C <= f(A, B') with B' = shifted B; next WB, except CMP.
  - ADD: A+B'.
  - SUB: A-B'.
  - AND: A&B'.
  - NOT: ~B'.
  - MOV: B'.
  - CMP: computes A-B' for flags only, writes no register, asserts done in EXE and returns to IDLE.
- Flags update at the end of EXE for ADD, SUB, AND, NOT, CMP.
  - Z = (result == 0).
  - N = result[DATA_W-1].
  - V = signed overflow for ADD/SUB/CMP; V = 0 for AND/NOT.
  - MOV and MOVI leave the flags unchanged.
- WB: rf_write = 1, rf_writenum = rd, done = 1; next IDLE.
  - rf_data_in = C, or sign-extended imm for MOVI.
- ERR: done = 1 and illegal = 1 for one cycle; no register-file side effect; next IDLE.
- Latency, counted in cycles after the accept edge until done:
  - MOVI: 1.
  - ERR: 1.
  - CMP: 3.
  - MOV, NOT: 3.
  - ADD, SUB, AND: 4.
- Back-to-back: in_ready returns in the cycle after done, so the minimum gap is one IDLE cycle.
- rd equal to rn or rm is legal. Sources are latched before WB, so in-place updates (e.g. R1 = R1 + R1) are exact.
- Arithmetic wraps modulo 2**DATA_W. Carry is discarded.

Optional Feature:
- Macro: REGFILE_SEQ_SHIFT_EN.
- Defined: B' = B shifted per the shift field, applied in EXE for all B-using ops.
  - 00: none.
  - 01: LSL 1 (zero fill).
  - 10: LSR 1 (zero fill).
  - 11: ASR 1 (MSB replicated).
- Undefined: the shift field is ignored and B' = B. Timing is identical either way.

Test Plan:
- Reset, then MOVI rd=3 imm=8'hFB -> one cycle later rf_write = 1, rf_writenum = 3, rf_data_in = 16'hFFFB, done = 1; flags unchanged (0).
- R1 = 16'h7FFF, R2 = 1; ADD rd=0 rn=1 rm=2 -> done 4 cycles after accept; R0 = 16'h8000; N = 1, V = 1, Z = 0.
- R4 = 5, R5 = 5; CMP rn=4 rm=5 -> done after 3 cycles; rf_write never asserted; Z = 1, N = 0, V = 0.
- op = 111 -> one cycle later done = 1 and illegal = 1; rf_write stays 0; returns to IDLE with in_ready = 1.
- Assert reset during WB of an ADD -> rf_write falls immediately; the destination register holds its old value; state IDLE and flags 0 after release.
- Shift:
  - With REGFILE_SEQ_SHIFT_EN: R6 = 16'h8002; MOV rd=7 rm=6 shift=11 -> R7 = 16'hC001.
  - Without the macro: same stimulus -> R7 = 16'h8002.
